// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage RAW hazard detector with a DEPTH-entry
// shift scoreboard of in-flight register writes and optional forwarding.
//
// Ports:
//   clk, reset          - rising-edge clock, synchronous active-high reset
//   instr_valid         - decode slot holds a real instruction
//   src_a/src_a_used    - rs field and its read enable
//   src_b/src_b_used    - rt field and its read enable
//   dst/dst_we/is_load  - destination, regfile write enable, load flag
//   flush               - kill the decode-slot instruction
//   hold                - freeze the scoreboard and counter
//   stall_out           - insert bubble, hold PC/IF/ID
//   fwd_sel_a/fwd_sel_b - 0 = regfile, k = forward from entry k-1
//   stall_count         - saturating stall-cycle counter
module hazard_scoreboard #(
    parameter int DEPTH   = 3,
    parameter int FORWARD = 0,
    parameter int CNT_W   = 16,
    parameter int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [4:0]       src_a,
    input  logic             src_a_used,
    input  logic [4:0]       src_b,
    input  logic             src_b_used,
    input  logic [4:0]       dst,
    input  logic             dst_we,
    input  logic             is_load,
    input  logic             flush,
    input  logic             hold,
    output logic             stall_out,
    output logic [SEL_W-1:0] fwd_sel_a,
    output logic [SEL_W-1:0] fwd_sel_b,
    output logic [CNT_W-1:0] stall_count
);

    // Entry 0 is the youngest instruction, just past decode.
    logic [DEPTH-1:0] sb_v;
    logic [DEPTH-1:0] sb_we;
    logic [DEPTH-1:0] sb_ld;
    logic [4:0]       sb_dst [DEPTH];

    logic [DEPTH-1:0] writing;
    logic [DEPTH-1:0] match_a;
    logic [DEPTH-1:0] match_b;
    logic [DEPTH-1:0] elig_a;
    logic [DEPTH-1:0] elig_b;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic             raw;

    always_comb begin
        writing = '0;
        match_a = '0;
        match_b = '0;
        elig_a  = '0;
        elig_b  = '0;
        for (int e = 0; e < DEPTH; e++) begin
            writing[e] = sb_v[e] & sb_we[e] & (sb_dst[e] != 5'd0);
            match_a[e] = src_a_used & writing[e] & (sb_dst[e] == src_a);
            match_b[e] = src_b_used & writing[e] & (sb_dst[e] == src_b);
            // A load still in entry 0 has no data yet; it cannot forward.
            elig_a[e]  = match_a[e] & ((e != 0) | ~sb_ld[e]);
            elig_b[e]  = match_b[e] & ((e != 0) | ~sb_ld[e]);
        end
    end

    // Scan oldest to youngest so the youngest producer wins.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int e = DEPTH - 1; e >= 0; e--) begin
            if (elig_a[e]) sel_a = SEL_W'(e + 1);
            if (elig_b[e]) sel_b = SEL_W'(e + 1);
        end
    end

    always_comb begin
        if (FORWARD != 0) raw = (match_a[0] | match_b[0]) & sb_ld[0];
        else              raw = (|match_a) | (|match_b);
    end

    assign stall_out = instr_valid & raw & ~flush & ~reset;

    always_comb begin
        fwd_sel_a = '0;
        fwd_sel_b = '0;
        if (FORWARD != 0 && !stall_out && !reset) begin
            fwd_sel_a = sel_a;
            fwd_sel_b = sel_b;
        end
    end

    // Valid bits and the counter carry reset; payload fields need none.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_v        <= '0;
            stall_count <= '0;
        end else if (!hold) begin
            for (int e = DEPTH - 1; e > 0; e--) sb_v[e] <= sb_v[e-1];
            sb_v[0] <= instr_valid & ~stall_out & ~flush;
            if (stall_out && !(&stall_count))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !hold) begin
            for (int e = DEPTH - 1; e > 0; e--) begin
                sb_dst[e] <= sb_dst[e-1];
                sb_we[e]  <= sb_we[e-1];
                sb_ld[e]  <= sb_ld[e-1];
            end
            sb_dst[0] <= dst;
            sb_we[0]  <= dst_we;
            sb_ld[0]  <= is_load;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of hazard_scoreboard in
// no-forwarding, forwarding and 4-bit-counter configurations.
module tb_hazard_scoreboard;

    logic       clk;
    logic       reset;
    logic       instr_valid;
    logic [4:0] src_a;
    logic       src_a_used;
    logic [4:0] src_b;
    logic       src_b_used;
    logic [4:0] dst;
    logic       dst_we;
    logic       is_load;
    logic       flush;
    logic       hold;

    logic        stall0, stall1, stall2;
    logic [1:0]  fa0, fb0, fa1, fb1, fa2, fb2;
    logic [15:0] cnt0, cnt1;
    logic [3:0]  cnt2;

    int n_chk;
    int n_err;

    hazard_scoreboard #(.DEPTH(3), .FORWARD(0), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid),
        .src_a(src_a), .src_a_used(src_a_used),
        .src_b(src_b), .src_b_used(src_b_used),
        .dst(dst), .dst_we(dst_we), .is_load(is_load),
        .flush(flush), .hold(hold), .stall_out(stall0),
        .fwd_sel_a(fa0), .fwd_sel_b(fb0), .stall_count(cnt0)
    );

    hazard_scoreboard #(.DEPTH(3), .FORWARD(1), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid),
        .src_a(src_a), .src_a_used(src_a_used),
        .src_b(src_b), .src_b_used(src_b_used),
        .dst(dst), .dst_we(dst_we), .is_load(is_load),
        .flush(flush), .hold(hold), .stall_out(stall1),
        .fwd_sel_a(fa1), .fwd_sel_b(fb1), .stall_count(cnt1)
    );

    hazard_scoreboard #(.DEPTH(3), .FORWARD(0), .CNT_W(4)) u2 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid),
        .src_a(src_a), .src_a_used(src_a_used),
        .src_b(src_b), .src_b_used(src_b_used),
        .dst(dst), .dst_we(dst_we), .is_load(is_load),
        .flush(flush), .hold(hold), .stall_out(stall2),
        .fwd_sel_a(fa2), .fwd_sel_b(fb2), .stall_count(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] a, input logic au,
                         input logic [4:0] b, input logic bu,
                         input logic [4:0] d, input logic we,
                         input logic ld);
        instr_valid = 1'b1;
        src_a = a; src_a_used = au;
        src_b = b; src_b_used = bu;
        dst = d; dst_we = we; is_load = ld;
    endtask

    task automatic bubble();
        instr_valid = 1'b0;
        src_a_used = 1'b0;
        src_b_used = 1'b0;
        dst_we = 1'b0;
        is_load = 1'b0;
    endtask

    task automatic do_reset();
        tick(); reset = 1'b1; bubble();
        tick(); reset = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        flush = 1'b0;
        hold  = 1'b0;
        src_a = '0; src_b = '0; dst = '0;
        bubble();
        tick(); tick();
        reset = 1'b0;

        // Reset in the middle of a stall
        tick(); issue(0, 0, 0, 0, 3, 1, 0);
        tick(); issue(3, 1, 0, 0, 4, 1, 0); #1;
        check("rst_pre_stall", stall0, 1);
        tick(); reset = 1'b1; #1;
        check("rst_stall_in_reset", stall0, 0);
        check("rst_fwd_in_reset", fa1, 0);
        check("rst_cnt_before_edge", cnt0, 1);
        tick(); #1;
        check("rst_cnt_cleared", cnt0, 0);
        check("rst_stall_2nd", stall0, 0);
        tick(); reset = 1'b0; #1;
        check("rst_release_stall", stall0, 0);
        check("rst_release_fwd", fa1, 0);

        // Back-to-back RAW, add $3 then add $4,$3,$5
        do_reset();
        tick(); issue(0, 0, 0, 0, 3, 1, 0);
        tick(); issue(3, 1, 5, 1, 4, 1, 0); #1;
        check("raw_stall_c1", stall0, 1);
        check("fwd_alu_e0", fa1, 1);
        check("fwd_alu_b", fb1, 0);
        check("fwd_alu_nostall", stall1, 0);
        tick(); #1;
        check("raw_stall_c2", stall0, 1);
        check("fwd_alu_e1", fa1, 2);
        tick(); #1;
        check("raw_stall_c3", stall0, 1);
        check("fwd_alu_e2", fa1, 3);
        tick(); #1;
        check("raw_release", stall0, 0);
        check("raw_count", cnt0, 3);

        // Load-use, lw $8 then add $10,$8,$8
        do_reset();
        tick(); issue(9, 1, 0, 0, 8, 1, 1);
        tick(); issue(8, 1, 8, 1, 10, 1, 0); #1;
        check("lu_stall", stall1, 1);
        check("lu_fwd_a_gated", fa1, 0);
        tick(); #1;
        check("lu_release", stall1, 0);
        check("lu_fwd_a", fa1, 2);
        check("lu_fwd_b", fb1, 2);
        check("lu_count", cnt1, 1);

        // Youngest producer wins, r0 and unused operands never match
        do_reset();
        tick(); issue(1, 1, 0, 0, 5, 1, 0);
        tick(); issue(2, 1, 0, 0, 5, 1, 0);
        tick(); issue(5, 1, 0, 1, 6, 1, 0); #1;
        check("yw_stall", stall1, 0);
        check("yw_fwd_a", fa1, 1);
        check("yw_fwd_b_r0", fb1, 0);
        tick(); issue(5, 0, 5, 1, 7, 1, 0); #1;
        check("yw_fwd_a_unused", fa1, 0);
        check("yw_fwd_b_e1", fb1, 2);

        // Flush overrides stall and inserts a bubble
        do_reset();
        tick(); issue(0, 0, 0, 0, 3, 1, 0);
        tick(); issue(3, 1, 0, 0, 3, 1, 0); flush = 1'b1; #1;
        check("fl_stall", stall0, 0);
        tick(); flush = 1'b0; #1;
        check("fl_bubble_fwd", fa1, 2);
        check("fl_stall_after", stall0, 1);
        check("fl_count", cnt0, 0);

        // Hold for 4 cycles during a stall
        do_reset();
        tick(); issue(0, 0, 0, 0, 3, 1, 0);
        tick(); issue(3, 1, 0, 0, 4, 1, 0); #1;
        check("hd_stall_pre", stall0, 1);
        tick(); hold = 1'b1; #1;
        check("hd_stall_h0", stall0, 1);
        check("hd_cnt_h0", cnt0, 1);
        for (int i = 1; i < 4; i++) begin
            tick(); #1;
            check("hd_stall_h", stall0, 1);
            check("hd_cnt_h", cnt0, 1);
        end
        tick(); hold = 1'b0; #1;
        check("hd_resume_stall", stall0, 1);
        check("hd_frozen_fwd", fa1, 2);
        check("hd_resume_cnt", cnt0, 1);
        tick(); #1;
        check("hd_stall_last", stall0, 1);
        check("hd_cnt_2", cnt0, 2);
        tick(); #1;
        check("hd_release", stall0, 0);
        check("hd_cnt_3", cnt0, 3);

        // Counter saturation at 15 with CNT_W=4
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            tick(); issue(0, 0, 0, 0, 3, 1, 0); #1;
            check("sat_prod_nostall", stall2, 0);
            check("sat_cnt", cnt2, (3 * (i - 1) > 15) ? 15 : 3 * (i - 1));
            for (int j = 0; j < 3; j++) begin
                tick(); issue(3, 1, 0, 0, 4, 1, 0); #1;
                check("sat_stall", stall2, 1);
            end
        end
        tick(); bubble(); #1;
        check("sat_cnt_final", cnt2, 15);
        check("sat_wide_cnt", cnt0, 18);
        tick(); #1;
        check("sat_cnt_hold15", cnt2, 15);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
